// File: rtl/cpu_axi_bridge_pkg.sv
// cpu_axi_bridge_pkg
// Shared constants for the CPU-to-AXI bridge: AXI read IDs that tell the
// instruction and data ports apart, the read/write FSM state encodings,
// and a helper that widens the 2-bit CPU size code to the 3-bit AXI size.
package cpu_axi_bridge_pkg;

    // AXI read IDs; the R channel rid selects which CPU port completes.
    localparam logic [3:0] ARID_INST = 4'd0;
    localparam logic [3:0] ARID_DATA = 4'd1;

    // Read FSM encoding.
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_AR   = 2'd1;
    localparam logic [1:0] RD_R    = 2'd2;

    // Write FSM encoding.
    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_AWW  = 2'd1;
    localparam logic [1:0] WR_B    = 2'd2;

    // CPU size (0=byte, 1=half, 2=word) maps straight onto AXI size.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
// Bridges two SRAM-style CPU ports (read-only instruction port, read/write
// data port) onto a single AXI master. One read and one write may be in
// flight at the same time, each tracked by its own FSM.
//
// Ports:
//   clk, reset                   core clock, synchronous active-high reset
//   inst_sram_*                  instruction port: req/addr/size in,
//                                addr_ok/data_ok/rdata out
//   data_sram_*                  data port: req/wr/size/addr/wstrb/wdata in,
//                                addr_ok/data_ok/rdata out
//   ar*/r*                       AXI read address and read data channels
//   aw*/w*/b*                    AXI write address, write data, response
//   rd_state_dbg, wr_state_dbg   current read / write FSM state
//
// Handshakes: an AXI transfer happens on a rising clk edge where both valid
// and ready are high; valid, once raised, stays high with its payload
// stable until that edge. On the CPU side a request is taken in the cycle
// where req and addr_ok are both high, and completion is the single cycle
// where data_ok is high.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    input  logic [1:0]  inst_sram_size,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready,

    output logic [1:0]  rd_state_dbg,
    output logic [1:0]  wr_state_dbg
);

    logic [1:0] rd_state;
    logic [1:0] wr_state;

    logic rd_idle;
    logic wr_idle;
    logic data_rd_req;
    logic data_rd_accept;
    logic data_wr_accept;
    logic r_fire;
    logic b_fire;

    assign rd_idle     = (rd_state == RD_IDLE);
    assign wr_idle     = (wr_state == WR_IDLE);
    assign data_rd_req = data_sram_req & ~data_sram_wr;

    // A data read also waits for the write FSM to drain, so a read can never
    // overtake an older write to the same address.
    assign data_wr_accept = ~reset & data_sram_req & data_sram_wr & wr_idle;
    assign data_rd_accept = ~reset & data_rd_req & rd_idle & wr_idle;

    assign data_sram_addr_ok = data_wr_accept | data_rd_accept;
    // A pending data read blocks the instruction port even while it is itself
    // stalled behind a write; data reads always have priority.
    assign inst_sram_addr_ok = ~reset & inst_sram_req & rd_idle & ~data_rd_req;

    // AXI control outputs follow the FSM state directly, so they are
    // registered and cannot glitch on CPU-side inputs.
    assign arvalid = (rd_state == RD_AR);
    assign rready  = (rd_state == RD_R);
    assign bready  = (wr_state == WR_B);

    assign r_fire = rvalid & rready;
    assign b_fire = bvalid & bready;

    assign inst_sram_data_ok = ~reset & r_fire & (rid == ARID_INST);
    assign data_sram_data_ok = ~reset & ((r_fire & (rid == ARID_DATA)) | b_fire);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign rd_state_dbg = rd_state;
    assign wr_state_dbg = wr_state;

    // Read FSM and AR payload latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            arid     <= 4'd0;
            araddr   <= 32'd0;
            arsize   <= 3'd0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (data_rd_accept) begin
                        arid     <= ARID_DATA;
                        araddr   <= data_sram_addr;
                        arsize   <= axi_size(data_sram_size);
                        rd_state <= RD_AR;
                    end else if (inst_sram_addr_ok) begin
                        arid     <= ARID_INST;
                        araddr   <= inst_sram_addr;
                        arsize   <= axi_size(inst_sram_size);
                        rd_state <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        rd_state <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write FSM and AW/W payload latch. AW and W complete independently;
    // the FSM leaves WR_AWW once neither channel has anything left to send,
    // which covers both handshakes landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            awaddr   <= 32'd0;
            awsize   <= 3'd0;
            wdata    <= 32'd0;
            wstrb    <= 4'd0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (data_wr_accept) begin
                        awaddr   <= data_sram_addr;
                        awsize   <= axi_size(data_sram_size);
                        wdata    <= data_sram_wdata;
                        wstrb    <= data_sram_wstrb;
                        awvalid  <= 1'b1;
                        wvalid   <= 1'b1;
                        wr_state <= WR_AWW;
                    end
                end
                WR_AWW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if ((~awvalid | awready) & (~wvalid | wready)) begin
                        wr_state <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    wr_state <= WR_IDLE;
                    awvalid  <= 1'b0;
                    wvalid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge
// Self-checking bench for cpu_axi_bridge. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_cpu_axi_bridge;
    import cpu_axi_bridge_pkg::*;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic [1:0]  inst_sram_size;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic [1:0]  rd_state_dbg;
    logic [1:0]  wr_state_dbg;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    cpu_axi_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arsize            (arsize),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdata),
        .rvalid            (rvalid),
        .rready            (rready),
        .awaddr            (awaddr),
        .awsize            (awsize),
        .awvalid           (awvalid),
        .awready           (awready),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .wvalid            (wvalid),
        .wready            (wready),
        .bvalid            (bvalid),
        .bready            (bready),
        .rd_state_dbg      (rd_state_dbg),
        .wr_state_dbg      (wr_state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_sram_req   = 1'b0;
        inst_sram_addr  = 32'd0;
        inst_sram_size  = 2'd0;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'd0;
        data_sram_wstrb = 4'd0;
        data_sram_wdata = 32'd0;
        arready = 1'b0;
        rid     = 4'd0;
        rdata   = 32'd0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Full read: request, AR accepted after ar_delay stall cycles, R returned
    // after r_delay stall cycles. The expected rdata goes into exp_q when the
    // request is accepted and is popped when data_ok appears.
    task automatic do_read(input bit is_data, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] value,
                           input int ar_delay, input int r_delay);
        logic [3:0]  exp_id;
        logic [31:0] exp_v;
        logic        got_ok;
        logic        other_ok;
        logic [31:0] got_rd;
        exp_id = is_data ? ARID_DATA : ARID_INST;
        if (is_data) begin
            data_sram_req = 1'b1; data_sram_wr = 1'b0;
            data_sram_addr = addr; data_sram_size = size;
        end else begin
            inst_sram_req = 1'b1; inst_sram_addr = addr; inst_sram_size = size;
        end
        @(negedge clk);
        got_ok = is_data ? data_sram_addr_ok : inst_sram_addr_ok;
        checks++;
        if (got_ok !== 1'b1) begin
            errors++;
            $display("FAIL read_addr_ok data=%0d got=%b exp=1", is_data, got_ok);
        end
        exp_q.push_back(value);
        step();
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        for (int c = 0; c <= ar_delay; c++) begin
            arready = (c == ar_delay);
            @(negedge clk);
            checks++;
            if (arvalid !== 1'b1 || araddr !== addr || arid !== exp_id ||
                arsize !== {1'b0, size} || rready !== 1'b0) begin
                errors++;
                $display("FAIL ar_channel got v=%b a=%h id=%h s=%h rr=%b exp v=1 a=%h id=%h s=%h rr=0",
                         arvalid, araddr, arid, arsize, rready, addr, exp_id, {1'b0, size});
            end
            step();
        end
        arready = 1'b0;
        for (int c = 0; c <= r_delay; c++) begin
            rvalid = (c == r_delay);
            rid    = exp_id;
            rdata  = (c == r_delay) ? value : 32'hDEAD_BEEF;
            @(negedge clk);
            got_ok   = is_data ? data_sram_data_ok : inst_sram_data_ok;
            other_ok = is_data ? inst_sram_data_ok : data_sram_data_ok;
            got_rd   = is_data ? data_sram_rdata : inst_sram_rdata;
            checks++;
            if (rready !== 1'b1 || arvalid !== 1'b0 || other_ok !== 1'b0 ||
                got_ok !== (c == r_delay)) begin
                errors++;
                $display("FAIL r_phase cyc=%0d got rready=%b arvalid=%b ok=%b other_ok=%b exp 1 0 %b 0",
                         c, rready, arvalid, got_ok, other_ok, (c == r_delay));
            end
            if (c == r_delay && got_ok === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_scoreboard got=%h exp=<empty queue>", got_rd);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_rd !== exp_v) begin
                        errors++;
                        $display("FAIL read_rdata got=%h exp=%h", got_rd, exp_v);
                    end
                end
            end
            step();
        end
        rvalid = 1'b0;
    endtask

    // Full write: AW accepted at stall cycle aw_delay, W at w_delay, B
    // returned after b_delay stall cycles.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] size,
                            input logic [3:0] strb, input logic [31:0] value,
                            input int aw_delay, input int w_delay, input int b_delay);
        int  n;
        bit  exp_aw;
        bit  exp_w;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = addr;
        data_sram_size = size; data_sram_wstrb = strb; data_sram_wdata = value;
        @(negedge clk);
        checks++;
        if (data_sram_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL write_addr_ok got=%b exp=1", data_sram_addr_ok);
        end
        step();
        data_sram_req = 1'b0;
        data_sram_wr  = 1'b0;
        n = (aw_delay > w_delay) ? aw_delay : w_delay;
        for (int c = 0; c <= n; c++) begin
            awready = (c == aw_delay);
            wready  = (c == w_delay);
            exp_aw  = (c <= aw_delay);
            exp_w   = (c <= w_delay);
            @(negedge clk);
            checks++;
            if (awvalid !== exp_aw || wvalid !== exp_w || bready !== 1'b0 ||
                (exp_aw && (awaddr !== addr || awsize !== {1'b0, size})) ||
                (exp_w && (wdata !== value || wstrb !== strb))) begin
                errors++;
                $display("FAIL aw_w_phase cyc=%0d got awv=%b wv=%b br=%b aa=%h as=%h wd=%h ws=%h exp awv=%b wv=%b br=0 aa=%h as=%h wd=%h ws=%h",
                         c, awvalid, wvalid, bready, awaddr, awsize, wdata, wstrb,
                         exp_aw, exp_w, addr, {1'b0, size}, value, strb);
            end
            step();
        end
        awready = 1'b0;
        wready  = 1'b0;
        for (int c = 0; c <= b_delay; c++) begin
            bvalid = (c == b_delay);
            @(negedge clk);
            checks++;
            if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
                data_sram_data_ok !== (c == b_delay) || inst_sram_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL b_phase cyc=%0d got br=%b awv=%b wv=%b dok=%b iok=%b exp 1 0 0 %b 0",
                         c, bready, awvalid, wvalid, data_sram_data_ok, inst_sram_data_ok,
                         (c == b_delay));
            end
            step();
        end
        bvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        inst_sram_req = 1'b1;
        data_sram_req = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr_ok got i=%b d=%b exp 0 0", inst_sram_addr_ok, data_sram_addr_ok);
        end
        step();
        reset = 1'b0;
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_state_dbg !== RD_IDLE || wr_state_dbg !== WR_IDLE ||
            arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            rready !== 1'b0 || bready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rs=%0d ws=%0d arv=%b awv=%b wv=%b rr=%b br=%b exp all 0",
                     rd_state_dbg, wr_state_dbg, arvalid, awvalid, wvalid, rready, bready);
        end
        checks++;
        if (araddr !== 32'd0 || awaddr !== 32'd0 || wdata !== 32'd0 || wstrb !== 4'd0 ||
            arsize !== 3'd0 || awsize !== 3'd0 || arid !== 4'd0) begin
            errors++;
            $display("FAIL reset_latches got ara=%h awa=%h wd=%h ws=%h exp all 0",
                     araddr, awaddr, wdata, wstrb);
        end
        checks++;
        if (inst_sram_addr_ok !== 1'b0 || data_sram_addr_ok !== 1'b0 ||
            inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got iao=%b dao=%b ido=%b ddo=%b exp 0 0 0 0",
                     inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok);
        end
        step();
    endtask

    task automatic test_inst_read();
        // addr_ok at cycle 0, AR at cycle 1, R at cycle 3.
        do_read(1'b0, 32'hBFC0_0000, 2'd2, 32'h3C08_0001, 0, 1);
        // Stalled arready: request held with stable AR payload.
        do_read(1'b0, 32'hBFC0_0004, 2'd2, 32'h2408_0005, 4, 0);
    endtask

    task automatic test_data_write();
        do_write(32'h8000_1000, 2'd1, 4'h3, 32'h0000_1234, 0, 3, 1);
        // AW and W in the same cycle go straight to WR_B.
        do_write(32'h8000_2000, 2'd2, 4'hF, 32'hCAFE_F00D, 2, 2, 0);
        // W before AW.
        do_write(32'h8000_3001, 2'd0, 4'h2, 32'h0000_AB00, 3, 1, 2);
    endtask

    task automatic test_arbitration();
        logic [31:0] exp_v;
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0100; inst_sram_size = 2'd2;
        data_sram_req = 1'b1; data_sram_wr = 1'b0;
        data_sram_addr = 32'h8000_0040; data_sram_size = 2'd2;
        @(negedge clk);
        checks++;
        if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_accept got d=%b i=%b exp d=1 i=0", data_sram_addr_ok, inst_sram_addr_ok);
        end
        exp_q.push_back(32'h1111_2222);
        step();
        data_sram_req = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || arid !== ARID_DATA || araddr !== 32'h8000_0040 ||
            inst_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_ar got v=%b id=%h a=%h iao=%b exp 1 1 80000040 0",
                     arvalid, arid, araddr, inst_sram_addr_ok);
        end
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = ARID_DATA; rdata = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if (data_sram_data_ok !== 1'b1 || inst_sram_data_ok !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_r got dok=%b iok=%b iao=%b exp 1 0 0",
                     data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok);
        end
        if (data_sram_data_ok === 1'b1) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (data_sram_rdata !== exp_v) begin
                errors++;
                $display("FAIL arb_rdata got=%h exp=%h", data_sram_rdata, exp_v);
            end
        end
        step();
        rvalid = 1'b0;
        inst_sram_req = 1'b0;
        // The held instruction request now goes through on the idle FSM.
        do_read(1'b0, 32'hBFC0_0100, 2'd2, 32'h0000_0042, 0, 0);
    endtask

    task automatic test_read_blocked_by_write();
        logic [31:0] exp_v;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_0080;
        data_sram_size = 2'd2; data_sram_wstrb = 4'hF; data_sram_wdata = 32'h5555_AAAA;
        step();
        data_sram_wr = 1'b0;
        data_sram_req = 1'b0;
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        data_sram_req = 1'b1; data_sram_wr = 1'b0;
        data_sram_addr = 32'h8000_0080; data_sram_size = 2'd2;
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0200;
        for (int c = 0; c < 3; c++) begin
            bvalid = (c == 2);
            @(negedge clk);
            checks++;
            if (wr_state_dbg !== WR_B || data_sram_addr_ok !== 1'b0 || inst_sram_addr_ok !== 1'b0 ||
                data_sram_data_ok !== (c == 2)) begin
                errors++;
                $display("FAIL blocked_in_wr_b cyc=%0d got ws=%0d dao=%b iao=%b dok=%b exp ws=2 0 0 %b",
                         c, wr_state_dbg, data_sram_addr_ok, inst_sram_addr_ok, data_sram_data_ok, (c == 2));
            end
            step();
        end
        bvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL unblocked_after_b got dao=%b iao=%b exp 1 0", data_sram_addr_ok, inst_sram_addr_ok);
        end
        exp_q.push_back(32'h5555_AAAA);
        step();
        data_sram_req = 1'b0;
        inst_sram_req = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || arid !== ARID_DATA) begin
            errors++;
            $display("FAIL blocked_ar got v=%b id=%h exp 1 1", arvalid, arid);
        end
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = ARID_DATA; rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (data_sram_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL blocked_r got dok=%b exp 1", data_sram_data_ok);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (data_sram_rdata !== exp_v) begin
                errors++;
                $display("FAIL blocked_rdata got=%h exp=%h", data_sram_rdata, exp_v);
            end
        end
        step();
        rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Read abandoned in RD_R.
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0300; inst_sram_size = 2'd2;
        step();
        inst_sram_req = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        reset = 1'b1;
        rvalid = 1'b1; rid = ARID_INST; rdata = 32'h7777_7777;
        @(negedge clk);
        checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_rd_r_data_ok got i=%b d=%b exp 0 0", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        reset = 1'b0;
        rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || inst_sram_data_ok !== 1'b0 ||
            data_sram_data_ok !== 1'b0 || rd_state_dbg !== RD_IDLE) begin
            errors++;
            $display("FAIL after_reset_rd got arv=%b rr=%b iok=%b dok=%b rs=%0d exp 0 0 0 0 0",
                     arvalid, rready, inst_sram_data_ok, data_sram_data_ok, rd_state_dbg);
        end
        step();
        // Write abandoned in WR_AWW.
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_0400;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'h1;
        step();
        data_sram_req = 1'b0; data_sram_wr = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || wr_state_dbg !== WR_IDLE) begin
            errors++;
            $display("FAIL after_reset_wr got awv=%b wv=%b br=%b ws=%0d exp 0 0 0 0",
                     awvalid, wvalid, bready, wr_state_dbg);
        end
        step();
        do_read(1'b0, 32'hBFC0_0300, 2'd2, 32'h8888_0000, 1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0: do_read(1'b0, $urandom & 32'hFFFF_FFFC, 2'd2, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(1'b1, $urandom, 2'($urandom_range(0, 2)), $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3));
                default: do_write($urandom, 2'($urandom_range(0, 2)), 4'($urandom_range(1, 15)),
                                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 3));
            endcase
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_inst_read();
        test_arbitration();
        test_data_write();
        test_read_blocked_by_write();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0 entries left", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, exposed as the ports below.
REQ-002 clk  in  1  core clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_sram_req / data_sram_req  in  1  port request valid.
REQ-005 inst_sram_addr / data_sram_addr  in  32  byte address.
REQ-006 inst_sram_size / data_sram_size  in  2  0=byte, 1=half, 2=word.
REQ-007 data_sram_wr / data_sram_wstrb / data_sram_wdata  in  1/4/32  write flag, byte enables, write data; the instruction port is read-only.
REQ-008 inst_sram_addr_ok / data_sram_addr_ok  out  1  request accepted this cycle.
REQ-009 inst_sram_data_ok / data_sram_data_ok  out  1  read data valid, or write complete.
REQ-010 inst_sram_rdata / data_sram_rdata  out  32  read data.
REQ-011 AR channel SHALL be: arid out 4, araddr out 32, arsize out 3, arvalid out 1, arready in 1.
REQ-012 R channel SHALL be: rid in 4, rdata in 32, rvalid in 1, rready out 1.
REQ-013 AW channel SHALL be: awaddr out 32, awsize out 3, awvalid out 1, awready in 1.
REQ-014 W channel SHALL be: wdata out 32, wstrb out 4, wvalid out 1, wready in 1.
REQ-015 B channel SHALL be: bvalid in 1, bready out 1.

Function
REQ-016 Read FSM states SHALL be RD_IDLE -> RD_AR (arvalid=1 until arready) -> RD_R (rready=1 until rvalid) -> RD_IDLE; at most one read SHALL be outstanding.
REQ-017 Write FSM states SHALL be WR_IDLE -> WR_AWW (awvalid and wvalid each drop independently on their own handshake) -> WR_B (bready=1 until bvalid) -> WR_IDLE; at most one write SHALL be outstanding.
REQ-018 data_sram_addr_ok SHALL be asserted when either condition holds: data_sram_req & data_sram_wr & WR_IDLE, or data_sram_req & ~data_sram_wr & RD_IDLE & WR_IDLE.
REQ-019 inst_sram_addr_ok SHALL be inst_sram_req & RD_IDLE & ~(data_sram_req & ~data_sram_wr); data reads SHALL win over instruction reads.
REQ-020 In the addr_ok cycle the bridge SHALL latch address, size, wstrb and wdata; arvalid/awvalid/wvalid SHALL rise the next cycle (registered outputs).
REQ-021 arid SHALL be 0 for an instruction read and 1 for a data read; arsize/awsize SHALL be {1'b0,size}.
REQ-022 On rvalid & rready: if rid==0, inst_sram_data_ok=1; if rid==1, data_sram_data_ok=1; rdata SHALL pass combinationally to both rdata outputs.
REQ-023 On bvalid & bready, data_sram_data_ok SHALL be 1 for exactly one cycle.
REQ-024 A read completion and a write completion in the same cycle on the data port SHALL NOT occur, because data reads are blocked while the write FSM is busy.
REQ-025 addr_ok SHALL never be asserted without the corresponding req in the same cycle.
REQ-026 A request SHALL NOT be lost when arready or awready/wready is held low indefinitely; the FSM SHALL remain in its current state and hold all AXI outputs stable.
REQ-027 When awready and wready arrive in the same cycle, the write FSM SHALL move directly to WR_B.

Reset
REQ-028 On reset both FSMs SHALL enter IDLE; arvalid, awvalid, wvalid, rready, bready, both addr_ok and both data_ok SHALL be 0; latched address/data registers SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction without completing it and SHALL return both FSMs to IDLE on the next edge.

Structure
REQ-030 The shared package SHALL hold ARID_INST=0, ARID_DATA=1 and the read and write FSM state encodings.
REQ-031 No sub-module SHALL be used; the block is two FSMs plus request latches.

Verification
REQ-032 Instruction read to 0xBFC00000 with arready=1 at cycle 1 and rvalid (rid=0, rdata=0x3C080001) at cycle 3 -> inst addr_ok at cycle 0; arvalid with araddr=0xBFC00000 at cycle 1; inst data_ok and rdata=0x3C080001 at cycle 3.
REQ-033 Instruction and data reads requested in the same cycle -> only data_addr_ok; arid=1; inst_addr_ok follows after the R handshake.
REQ-034 Data write (addr 0x80001000, wstrb=0x3, wdata=0x1234) with awready at cycle 1 and wready at cycle 4 -> awvalid drops after cycle 1; wvalid holds until cycle 4; data_ok on bvalid.
REQ-035 Data read requested while the write FSM is in WR_B -> data_addr_ok=0 until the cycle after bvalid.
REQ-036 Reset asserted during RD_R -> arvalid=0, rready=0 and both data_ok=0 on the next cycle; a new request is accepted after reset is released.
